// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the round-robin RAM arbiter: FSM state encoding
// and the index-width helper used to size grant/pointer registers.
package mem_arbiter_pkg;

    // Arbiter FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Bits needed to index 'value' items; never returns less than 1 so a
    // 1-deep counter or a 2-core grant index still gets a real bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width_v;
        width_v = 32'd1;
        for (int unsigned i = 32'd1; i < 32'd31; i++) begin
            if ((32'd1 << i) < value) begin
                width_v = i + 32'd1;
            end else begin
                width_v = width_v;
            end
        end
        return width_v;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first requesting core at or
// after the slot following last_grant, wrapping around the core vector.
module rr_priority_picker
    import mem_arbiter_pkg::*;
#(
    parameter int CORE_NUM = 4,
    parameter int IDX_W    = int'(clog2(CORE_NUM))
) (
    input  logic [CORE_NUM-1:0] request,
    input  logic [IDX_W-1:0]    last_grant,
    output logic                any_req,
    output logic [IDX_W-1:0]    grant
);

    assign any_req = |request;

    // Scan CORE_NUM slots starting one past the previous winner; first hit wins.
    always_comb begin
        logic             found_s;
        logic [IDX_W-1:0] idx_s;
        found_s = 1'b0;
        grant   = '0;
        idx_s   = '0;
        for (int k = 1; k <= CORE_NUM; k++) begin
            idx_s = IDX_W'((int'(last_grant) + k) % CORE_NUM);
            if (!found_s && request[idx_s]) begin
                found_s = 1'b1;
                grant   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter giving CORE_NUM cores one-at-a-time access to a
// single-port synchronous RAM with configurable read latency.
module mem_arbiter_rr
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int CORE_NUM     = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CORE_NUM-1:0]            request,
    input  logic [CORE_NUM-1:0]            wren_core,
    input  logic [CORE_NUM*ADDR_WIDTH-1:0] address_in,
    input  logic [CORE_NUM*WIDTH-1:0]      data_in,
    output logic [CORE_NUM*WIDTH-1:0]      data_out,
    output logic [CORE_NUM-1:0]            response,
    output logic [ADDR_WIDTH-1:0]          address,
    output logic [WIDTH-1:0]               data_write,
    output logic                           wren,
    input  logic [WIDTH-1:0]               data_read
);

    localparam int IDX_W = int'(clog2(CORE_NUM));
    localparam int CNT_W = int'(clog2(READ_LATENCY + 1));

    arb_state_e       state_r;
    logic [IDX_W-1:0] last_grant_r;
    logic [IDX_W-1:0] grant_r;
    logic             is_write_r;
    logic [CNT_W-1:0] cnt_r;

    logic             any_req_s;
    logic [IDX_W-1:0] pick_s;

    logic [ADDR_WIDTH-1:0] addr_arr_s [CORE_NUM];
    logic [WIDTH-1:0]      wdata_arr_s [CORE_NUM];
    logic [WIDTH-1:0]      data_out_r [CORE_NUM];

    // Unpack the flat per-core buses into arrays so the winner can be indexed.
    for (genvar i = 0; i < CORE_NUM; i++) begin : g_lanes
        assign addr_arr_s[i]                = address_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr_s[i]               = data_in[i*WIDTH +: WIDTH];
        assign data_out[i*WIDTH +: WIDTH]   = data_out_r[i];
    end

    rr_priority_picker #(
        .CORE_NUM (CORE_NUM),
        .IDX_W    (IDX_W)
    ) u_picker (
        .request    (request),
        .last_grant (last_grant_r),
        .any_req    (any_req_s),
        .grant      (pick_s)
    );

    // Transaction FSM: grant in IDLE, drive RAM for one ISSUE cycle, wait out
    // the read latency, then pulse the winner's response for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= IDX_W'(CORE_NUM - 1);
            grant_r      <= '0;
            is_write_r   <= 1'b0;
            cnt_r        <= '0;
            response     <= '0;
            wren         <= 1'b0;
            address      <= '0;
            data_write   <= '0;
            for (int i = 0; i < CORE_NUM; i++) begin
                data_out_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    response <= '0;
                    if (any_req_s) begin
                        grant_r      <= pick_s;
                        last_grant_r <= pick_s;
                        address      <= addr_arr_s[pick_s];
                        data_write   <= wdata_arr_s[pick_s];
                        wren         <= wren_core[pick_s];
                        is_write_r   <= wren_core[pick_s];
                        state_r      <= ST_ISSUE;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    // RAM samples address/data/wren at the end of this cycle.
                    wren <= 1'b0;
                    if (is_write_r) begin
                        response[grant_r] <= 1'b1;
                        state_r           <= ST_RESP;
                    end else begin
                        cnt_r   <= CNT_W'(READ_LATENCY);
                        state_r <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == CNT_W'(1)) begin
                        data_out_r[grant_r] <= data_read;
                        response[grant_r]   <= 1'b1;
                        state_r             <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    response <= '0;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    response <= '0;
                    wren     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
